// File: rtl/redbus_arbiter.sv
// -----------------------------------------------------------------------------
// redbus_arbiter
//
// Shares the single Redbus (address, device id, data, Read/Write strobes)
// between two masters: M0 (CPU) and M1 (DMA / secondary master). Each access
// runs IDLE -> SETUP -> STROBE (STROBE_CYCLES cycles) -> HOLD -> IDLE. Address,
// device id and write data are loaded only when SETUP is entered, so they stay
// stable on both sides of every strobe edge.
//
// Parameters
//   ADDR_W, DATA_W, DEV_W  bus field widths
//   STROBE_CYCLES          cycles a strobe stays high, 1..15
//   FIXED_PRIO             0 = round-robin tie-break, 1 = M0 always wins a tie
//
// Ports
//   i_clock, i_reset        system clock; synchronous active-high reset
//   i_m{0,1}_req            access request, held until the matching ack
//   i_m{0,1}_we/addr/dev/wdata  access attributes, sampled at grant
//   o_m{0,1}_ack            one-cycle completion pulse (HOLD cycle)
//   o_rd_data               last read result, updated as HOLD is entered
//   o_grant                 one-hot owner during SETUP..HOLD, 00 in IDLE
//   o_address, o_redbus_device, o_bus_data_out  bus fields
//   o_bus_data_oe           arbiter drives bus data (writes only)
//   i_bus_data_in           read data from the bus
//   o_read, o_write         Redbus strobes
// -----------------------------------------------------------------------------
module redbus_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 9,
    parameter int DEV_W         = 9,
    parameter int STROBE_CYCLES = 2,
    parameter int FIXED_PRIO    = 0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DEV_W-1:0]  i_m0_dev,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DEV_W-1:0]  i_m1_dev,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m0_ack,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [1:0]        o_grant,
    output logic [ADDR_W-1:0] o_address,
    output logic [DEV_W-1:0]  o_redbus_device,
    output logic [DATA_W-1:0] o_bus_data_out,
    output logic              o_bus_data_oe,
    input  logic [DATA_W-1:0] i_bus_data_in,
    output logic              o_read,
    output logic              o_write
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                r_last_m1;      // 1: M1 was granted most recently
    logic                w_last_m1_nxt;
    logic                r_we;           // latched direction of the current access
    logic                w_we_nxt;
    logic                w_pick_m1;
    logic                w_any_req;

    logic [1:0]          w_grant_nxt;
    logic [ADDR_W-1:0]   w_address_nxt;
    logic [DEV_W-1:0]    w_dev_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic                w_oe_nxt;
    logic                w_read_nxt;
    logic                w_write_nxt;
    logic                w_m0_ack_nxt;
    logic                w_m1_ack_nxt;
    logic [DATA_W-1:0]   w_rd_data_nxt;

    assign w_any_req = i_m0_req | i_m1_req;

    // Winner selection: a lone requester wins; a tie goes to M0 in fixed mode,
    // otherwise to the master that was not granted last.
    always_comb begin
        w_pick_m1 = 1'b0;
        if (i_m0_req && i_m1_req) begin
            if (FIXED_PRIO != 0) begin
                w_pick_m1 = 1'b0;
            end else begin
                w_pick_m1 = ~r_last_m1;
            end
        end else begin
            w_pick_m1 = i_m1_req;
        end
    end

    // Next-state and next-output logic; every output is registered, so the
    // values computed here are what the bus shows in the following cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_last_m1_nxt = r_last_m1;
        w_we_nxt      = r_we;
        w_grant_nxt   = o_grant;
        w_address_nxt = o_address;
        w_dev_nxt     = o_redbus_device;
        w_wdata_nxt   = o_bus_data_out;
        w_oe_nxt      = o_bus_data_oe;
        w_read_nxt    = 1'b0;
        w_write_nxt   = 1'b0;
        w_m0_ack_nxt  = 1'b0;
        w_m1_ack_nxt  = 1'b0;
        w_rd_data_nxt = o_rd_data;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    // Grant: the bus fields are loaded straight from the
                    // winner, which makes them the latched copies for the
                    // whole access.
                    w_state_nxt   = ST_SETUP;
                    w_cnt_nxt     = 4'd0;
                    w_last_m1_nxt = w_pick_m1;
                    if (w_pick_m1) begin
                        w_we_nxt      = i_m1_we;
                        w_grant_nxt   = 2'b10;
                        w_address_nxt = i_m1_addr;
                        w_dev_nxt     = i_m1_dev;
                        w_wdata_nxt   = i_m1_wdata;
                        w_oe_nxt      = i_m1_we;
                    end else begin
                        w_we_nxt      = i_m0_we;
                        w_grant_nxt   = 2'b01;
                        w_address_nxt = i_m0_addr;
                        w_dev_nxt     = i_m0_dev;
                        w_wdata_nxt   = i_m0_wdata;
                        w_oe_nxt      = i_m0_we;
                    end
                end else begin
                    w_grant_nxt = 2'b00;
                    w_oe_nxt    = 1'b0;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_STROBE;
                w_cnt_nxt   = 4'd0;
                w_read_nxt  = ~r_we;
                w_write_nxt = r_we;
            end
            ST_STROBE: begin
                if (r_cnt == STROBE_LAST) begin
                    // Last strobe cycle: reads take the bus value now, and the
                    // ack is raised for the HOLD cycle.
                    w_state_nxt  = ST_HOLD;
                    w_cnt_nxt    = 4'd0;
                    w_m0_ack_nxt = o_grant[0];
                    w_m1_ack_nxt = o_grant[1];
                    if (!r_we) begin
                        w_rd_data_nxt = i_bus_data_in;
                    end else begin
                        w_rd_data_nxt = o_rd_data;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                    w_read_nxt  = ~r_we;
                    w_write_nxt = r_we;
                end
            end
            ST_HOLD: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
                w_oe_nxt    = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
                w_oe_nxt    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset (aborts any access).
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= 4'd0;
            r_last_m1       <= 1'b1;
            r_we            <= 1'b0;
            o_grant         <= 2'b00;
            o_address       <= '0;
            o_redbus_device <= '0;
            o_bus_data_out  <= '0;
            o_bus_data_oe   <= 1'b0;
            o_read          <= 1'b0;
            o_write         <= 1'b0;
            o_m0_ack        <= 1'b0;
            o_m1_ack        <= 1'b0;
            o_rd_data       <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_last_m1       <= w_last_m1_nxt;
            r_we            <= w_we_nxt;
            o_grant         <= w_grant_nxt;
            o_address       <= w_address_nxt;
            o_redbus_device <= w_dev_nxt;
            o_bus_data_out  <= w_wdata_nxt;
            o_bus_data_oe   <= w_oe_nxt;
            o_read          <= w_read_nxt;
            o_write         <= w_write_nxt;
            o_m0_ack        <= w_m0_ack_nxt;
            o_m1_ack        <= w_m1_ack_nxt;
            o_rd_data       <= w_rd_data_nxt;
        end
    end

endmodule

// File: tb/tb_redbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_redbus_arbiter
//
// Drives four arbiter instances from the same master/bus stimulus:
//   0: round-robin, 2 strobe cycles   1: fixed priority, 2 strobe cycles
//   2: round-robin, 1 strobe cycle    3: fixed priority, 15 strobe cycles
// A transaction-level reference model per instance tracks the position inside
// the current access (-1 = bus free) and the captured access attributes, and
// predicts every output after each clock edge.
// -----------------------------------------------------------------------------
module tb_redbus_arbiter;

    localparam int NI = 4;
    localparam int SC_TAB [NI] = '{2, 2, 1, 15};
    localparam int FP_TAB [NI] = '{0, 1, 0, 1};

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m1_addr;
    logic [8:0]  m0_dev, m1_dev, m0_wdata, m1_wdata;
    logic [8:0]  bus_in;

    logic        m0_ack   [NI];
    logic        m1_ack   [NI];
    logic [8:0]  rd_data  [NI];
    logic [1:0]  grant    [NI];
    logic [15:0] address  [NI];
    logic [8:0]  dev      [NI];
    logic [8:0]  bus_out  [NI];
    logic        bus_oe   [NI];
    logic        rd_strb  [NI];
    logic        wr_strb  [NI];

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_pos  [NI];   // -1 idle, 0 setup, 1..SC strobe, SC+1 hold
    logic        m_own  [NI];   // 1 = M1 owns the current access
    logic        m_last [NI];
    logic        m_we   [NI];
    logic [15:0] m_addr [NI];
    logic [8:0]  m_dev  [NI];
    logic [8:0]  m_wd   [NI];
    logic [8:0]  m_rd   [NI];

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            redbus_arbiter #(
                .ADDR_W(16), .DATA_W(9), .DEV_W(9),
                .STROBE_CYCLES(SC_TAB[g]), .FIXED_PRIO(FP_TAB[g])
            ) u_dut (
                .i_clock(clk), .i_reset(rst),
                .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
                .i_m0_dev(m0_dev), .i_m0_wdata(m0_wdata),
                .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
                .i_m1_dev(m1_dev), .i_m1_wdata(m1_wdata),
                .o_m0_ack(m0_ack[g]), .o_m1_ack(m1_ack[g]),
                .o_rd_data(rd_data[g]), .o_grant(grant[g]),
                .o_address(address[g]), .o_redbus_device(dev[g]),
                .o_bus_data_out(bus_out[g]), .o_bus_data_oe(bus_oe[g]),
                .i_bus_data_in(bus_in),
                .o_read(rd_strb[g]), .o_write(wr_strb[g])
            );
        end
    endgenerate

    // free-running system clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply the current inputs to the model as the DUTs will see them at the next edge.
    task automatic model_advance();
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_pos[k] = -1; m_own[k] = 1'b0; m_last[k] = 1'b1; m_we[k] = 1'b0;
                m_addr[k] = '0; m_dev[k] = '0; m_wd[k] = '0; m_rd[k] = '0;
            end else if (m_pos[k] < 0) begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req)
                        m_own[k] = (FP_TAB[k] != 0) ? 1'b0 : !m_last[k];
                    else
                        m_own[k] = m1_req;
                    m_last[k] = m_own[k];
                    m_we[k]   = m_own[k] ? m1_we    : m0_we;
                    m_addr[k] = m_own[k] ? m1_addr  : m0_addr;
                    m_dev[k]  = m_own[k] ? m1_dev   : m0_dev;
                    m_wd[k]   = m_own[k] ? m1_wdata : m0_wdata;
                    m_pos[k]  = 0;
                end
            end else if (m_pos[k] == SC_TAB[k] + 1) begin
                m_pos[k] = -1;
            end else begin
                if (m_pos[k] == SC_TAB[k] && !m_we[k]) m_rd[k] = bus_in;
                m_pos[k]++;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            logic [1:0] eg;
            logic       act, strb, hold;
            act  = (m_pos[k] >= 0);
            strb = (m_pos[k] >= 1) && (m_pos[k] <= SC_TAB[k]);
            hold = (m_pos[k] == SC_TAB[k] + 1);
            eg   = !act ? 2'b00 : (m_own[k] ? 2'b10 : 2'b01);
            chk($sformatf("i%0d_grant", k),   32'(grant[k]),   32'(eg));
            chk($sformatf("i%0d_read", k),    32'(rd_strb[k]), 32'(strb && !m_we[k]));
            chk($sformatf("i%0d_write", k),   32'(wr_strb[k]), 32'(strb && m_we[k]));
            chk($sformatf("i%0d_m0ack", k),   32'(m0_ack[k]),  32'(hold && !m_own[k]));
            chk($sformatf("i%0d_m1ack", k),   32'(m1_ack[k]),  32'(hold && m_own[k]));
            chk($sformatf("i%0d_oe", k),      32'(bus_oe[k]),  32'(act && m_we[k]));
            chk($sformatf("i%0d_addr", k),    32'(address[k]), 32'(m_addr[k]));
            chk($sformatf("i%0d_dev", k),     32'(dev[k]),     32'(m_dev[k]));
            chk($sformatf("i%0d_wdata", k),   32'(bus_out[k]), 32'(m_wd[k]));
            chk($sformatf("i%0d_rdata", k),   32'(rd_data[k]), 32'(m_rd[k]));
        end
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int found;
        clk = 1'b0; rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_dev = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_dev = '0; m1_wdata = '0;
        bus_in = '0;
        for (int k = 0; k < NI; k++) m_pos[k] = -1;
        #2;
        step(); step();
        rst = 1'b0;
        step();

        // M0 read of device 1, bus returns 0x1A5
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010; m0_dev = 9'd1; bus_in = 9'h1A5;
        step(); step(); step();
        m0_req = 1'b0;
        for (int i = 0; i < 20; i++) step();
        for (int k = 0; k < NI; k++) chk($sformatf("t1_rd%0d", k), 32'(rd_data[k]), 32'h1A5);

        // M1 write of 0x0C3 to device 2 at 0xBEEF
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'hBEEF; m1_dev = 9'd2; m1_wdata = 9'h0C3;
        bus_in = 9'h055;
        step(); step(); step();
        m1_req = 1'b0;
        for (int i = 0; i < 20; i++) step();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("t2_rd%0d", k),   32'(rd_data[k]), 32'h1A5);
            chk($sformatf("t2_addr%0d", k), 32'(address[k]), 32'hBEEF);
            chk($sformatf("t2_wd%0d", k),   32'(bus_out[k]), 32'h0C3);
        end

        // both masters requesting continuously
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h1111;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h2222;
        for (int i = 0; i < 40; i++) step();
        m0_req = 1'b0;
        for (int i = 0; i < 40; i++) step();
        m1_req = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // reset in the middle of a write strobe
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h1234; m1_wdata = 9'h0AA;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            step();
            if (m_pos[0] == 1) found = 1;
        end
        chk("t5_reach_strobe", 32'(found), 32'd1);
        rst = 1'b1;
        step();
        chk("t5_write", 32'(wr_strb[0]), 32'd0);
        chk("t5_grant", 32'(grant[0]), 32'd0);
        rst = 1'b0;
        step(); step();
        m1_req = 1'b0;
        for (int i = 0; i < 25; i++) step();

        // randomized traffic, changing attributes and occasional resets
        for (int i = 0; i < 3000; i++) begin
            m0_req   = ($urandom_range(0, 99) < 60);
            m1_req   = ($urandom_range(0, 99) < 60);
            m0_we    = 1'($urandom);
            m1_we    = 1'($urandom);
            m0_addr  = 16'($urandom);
            m1_addr  = 16'($urandom);
            m0_dev   = 9'($urandom);
            m1_dev   = 9'($urandom);
            m0_wdata = 9'($urandom);
            m1_wdata = 9'($urandom);
            bus_in   = 9'($urandom);
            rst      = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
